// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and helpers for the cpu run monitor: run-state encoding,
// default widths matching the cpu, and a saturating increment.
package cpu_run_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } run_state_t;

  localparam int CPU_DATA_W = 64;
  localparam int CPU_CNT_W  = 32;

  // Counters up to 64 bits share this helper; callers pass their own ceiling.
  localparam int SAT_W = 64;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_value);
    return (value >= max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/cpu_run_monitor_fifo.sv
// Synchronous show-ahead FIFO; head is 0 while empty. Pointers carry one
// extra wrap bit so full/empty/level fall out of a subtraction.
module mon_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign o_level  = r_wr_ptr - r_rd_ptr;
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush && w_push_ok)
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller beside the cpu: sequences start -> halt/timeout, counts
// RUN cycles and output strobes, and buffers output words for later draining.
module cpu_run_monitor #(
  parameter int DATA_W  = cpu_run_monitor_pkg::CPU_DATA_W,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = cpu_run_monitor_pkg::CPU_CNT_W,
  parameter int TIMEOUT = 100000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_cpu_halt,
  input  logic                     i_cpu_out_signal,
  input  logic [DATA_W-1:0]        i_cpu_out_data,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_rd_valid,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic                     o_running,
  output logic                     o_done,
  output logic                     o_timed_out,
  output logic                     o_overflow,
  output logic [CNT_W-1:0]         o_cycle_count,
  output logic [CNT_W-1:0]         o_out_count,
  output logic [CNT_W-1:0]         o_drop_count
);

  import cpu_run_monitor_pkg::*;

  localparam logic [SAT_W-1:0] CNT_MAX = {SAT_W{1'b1}} >> (SAT_W - CNT_W);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  run_state_t       r_state;
  run_state_t       w_next_state;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_out_count;
  logic [CNT_W-1:0] r_drop_count;
  logic             r_overflow;

  logic w_in_run;
  logic w_timeout_hit;
  logic w_strobe;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_fifo_full;
  logic w_fifo_empty;

  // start acts as a flush: it masks capture and pop for the cycle it is seen.
  assign w_in_run      = (r_state == RUN);
  assign w_timeout_hit = (TIMEOUT != 0) && (r_cycle_count == TO_LAST);
  assign w_strobe      = w_in_run && i_cpu_out_signal && !i_start;
  assign w_pop         = i_rd_en && !w_fifo_empty && !i_start;
  assign w_drop        = w_strobe && w_fifo_full && !w_pop;
  assign w_push        = w_strobe && !w_drop;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (i_start) begin
      w_next_state = RUN;
    end else if (r_state == RUN) begin
      if (i_cpu_halt)         w_next_state = HALTED;
      else if (w_timeout_hit) w_next_state = cpu_run_monitor_pkg::TIMEOUT;
    end
  end

  always_comb begin
    o_running   = (r_state == RUN);
    o_done      = (r_state == HALTED);
    o_timed_out = (r_state == cpu_run_monitor_pkg::TIMEOUT);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_start) begin
      r_cycle_count <= '0;
      r_out_count   <= '0;
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
    end else if (w_in_run) begin
      r_cycle_count <= CNT_W'(sat_inc(SAT_W'(r_cycle_count), CNT_MAX));
      if (w_strobe) r_out_count <= CNT_W'(sat_inc(SAT_W'(r_out_count), CNT_MAX));
      if (w_drop) begin
        r_drop_count <= CNT_W'(sat_inc(SAT_W'(r_drop_count), CNT_MAX));
        r_overflow   <= 1'b1;
      end
    end
  end

  assign o_cycle_count = r_cycle_count;
  assign o_out_count   = r_out_count;
  assign o_drop_count  = r_drop_count;
  assign o_overflow    = r_overflow;
  assign o_rd_valid    = !w_fifo_empty;

  mon_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_start),
    .i_push      (w_push),
    .i_push_data (i_cpu_out_data),
    .i_pop       (w_pop),
    .o_head      (o_rd_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (o_fifo_level)
  );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: status/counter checks after each step,
// and a scoreboard queue of captured words checked whenever the FIFO is popped.
module tb_cpu_run_monitor;

  localparam int DATA_W  = 64;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 20;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              cpuHalt = 1'b0;
  logic              cpuOutSignal = 1'b0;
  logic [DATA_W-1:0] cpuOutData = '0;
  logic              rdEn = 1'b0;

  logic [DATA_W-1:0] rdData;
  logic              rdValid;
  logic [LVL_W-1:0]  fifoLevel;
  logic              running;
  logic              done;
  logic              timedOut;
  logic              overflow;
  logic [CNT_W-1:0]  cycleCount;
  logic [CNT_W-1:0]  outCount;
  logic [CNT_W-1:0]  dropCount;

  logic [63:0] expQ[$];
  logic [63:0] monExp;
  int testsRun = 0;
  int testsFailed = 0;

  cpu_run_monitor #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_start          (start),
    .i_cpu_halt       (cpuHalt),
    .i_cpu_out_signal (cpuOutSignal),
    .i_cpu_out_data   (cpuOutData),
    .i_rd_en          (rdEn),
    .o_rd_data        (rdData),
    .o_rd_valid       (rdValid),
    .o_fifo_level     (fifoLevel),
    .o_running        (running),
    .o_done           (done),
    .o_timed_out      (timedOut),
    .o_overflow       (overflow),
    .o_cycle_count    (cycleCount),
    .o_out_count      (outCount),
    .o_drop_count     (dropCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock of stimulus; words the bench expects captured go into the scoreboard.
  task automatic applyStimulus(input logic st, input logic halt, input logic sig,
                               input logic [63:0] data, input logic rd, input logic expectCapture);
    start        = st;
    cpuHalt      = halt;
    cpuOutSignal = sig;
    cpuOutData   = data;
    rdEn         = rd;
    if (st) expQ.delete();
    if (expectCapture) expQ.push_back(data);
    @(posedge clk);
    #1;
    start        = 1'b0;
    cpuHalt      = 1'b0;
    cpuOutSignal = 1'b0;
    cpuOutData   = '0;
    rdEn         = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".running"},  64'(running),    0);
    checkOutput({tag, ".done"},     64'(done),       0);
    checkOutput({tag, ".timedOut"}, 64'(timedOut),   0);
    checkOutput({tag, ".overflow"}, 64'(overflow),   0);
    checkOutput({tag, ".rdValid"},  64'(rdValid),    0);
    checkOutput({tag, ".rdData"},   rdData,          0);
    checkOutput({tag, ".level"},    64'(fifoLevel),  0);
    checkOutput({tag, ".cycles"},   64'(cycleCount), 0);
    checkOutput({tag, ".outs"},     64'(outCount),   0);
    checkOutput({tag, ".drops"},    64'(dropCount),  0);
  endtask

  // Scoreboard monitor: every requested pop must find data, and the right data.
  always @(negedge clk) begin
    if (!reset && rdEn && !start) begin
      checkOutput("popValid", 64'(rdValid), 64'(expQ.size() != 0));
      if (rdValid && expQ.size() != 0) begin
        monExp = expQ.pop_front();
        checkOutput("popData", rdData, monExp);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyReset();
    applyReset();
    checkAllZero("reset");

    // Basic run: words on RUN cycles 2..4, halt on cycle 6.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("startRunning", 64'(running), 1);
    checkOutput("startCycles", 64'(cycleCount), 0);
    idleCycles(1);
    applyStimulus(0, 0, 1, 5, 0, 1);
    checkOutput("pushLatency", rdData, 5);
    applyStimulus(0, 0, 1, 7, 0, 1);
    applyStimulus(0, 0, 1, 9, 0, 1);
    idleCycles(1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("haltDone", 64'(done), 1);
    checkOutput("haltRunning", 64'(running), 0);
    checkOutput("haltCycles", 64'(cycleCount), 6);
    checkOutput("haltOuts", 64'(outCount), 3);
    checkOutput("haltLevel", 64'(fifoLevel), 3);
    applyStimulus(0, 0, 1, 77, 0, 0);
    checkOutput("haltedIgnoreStrobe", 64'(outCount), 3);
    checkOutput("haltedFrozenCycles", 64'(cycleCount), 6);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("drainedValid", 64'(rdValid), 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("underflowLevel", 64'(fifoLevel), 0);
    checkOutput("underflowData", rdData, 0);

    // Watchdog: no halt, timeout on the 20th RUN cycle.
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleCycles(TIMEOUT - 1);
    checkOutput("preTimeoutRunning", 64'(running), 1);
    checkOutput("preTimeoutCycles", 64'(cycleCount), TIMEOUT - 1);
    idleCycles(1);
    checkOutput("timeoutFlag", 64'(timedOut), 1);
    checkOutput("timeoutRunning", 64'(running), 0);
    checkOutput("timeoutCycles", 64'(cycleCount), TIMEOUT);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("lateHaltDone", 64'(done), 0);
    checkOutput("lateHaltTimedOut", 64'(timedOut), 1);
    checkOutput("lateHaltCycles", 64'(cycleCount), TIMEOUT);

    // Overflow: six words into a four-deep FIFO.
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int v = 1; v <= 6; v++) begin
      applyStimulus(0, 0, 1, 64'(v), 0, v <= DEPTH);
      if (v == DEPTH) checkOutput("fullNoOverflow", 64'(overflow), 0);
    end
    checkOutput("ovfLevel", 64'(fifoLevel), DEPTH);
    checkOutput("ovfFlag", 64'(overflow), 1);
    checkOutput("ovfDrops", 64'(dropCount), 2);
    checkOutput("ovfOuts", 64'(outCount), 6);
    checkOutput("ovfHead", rdData, 1);

    // Full FIFO with push and pop together: no drop, 99 lands at the tail.
    applyStimulus(0, 0, 1, 99, 1, 1);
    checkOutput("pushPopLevel", 64'(fifoLevel), DEPTH);
    checkOutput("pushPopDrops", 64'(dropCount), 2);
    checkOutput("pushPopHead", rdData, 2);
    checkOutput("pushPopOuts", 64'(outCount), 7);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("pushPopDrained", 64'(fifoLevel), 0);

    // Halt and strobe together: word captured, then HALTED.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("restartOverflow", 64'(overflow), 0);
    applyStimulus(0, 1, 1, 42, 0, 1);
    checkOutput("haltStrobeDone", 64'(done), 1);
    checkOutput("haltStrobeLevel", 64'(fifoLevel), 1);
    checkOutput("haltStrobeOuts", 64'(outCount), 1);
    checkOutput("haltStrobeCycles", 64'(cycleCount), 1);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Halt and timeout on the same cycle: halt wins.
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleCycles(TIMEOUT - 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("haltVsTimeoutDone", 64'(done), 1);
    checkOutput("haltVsTimeoutTimedOut", 64'(timedOut), 0);
    checkOutput("haltVsTimeoutCycles", 64'(cycleCount), TIMEOUT);

    // Restart while running with a full, overflowed FIFO.
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int v = 10; v <= 14; v++) applyStimulus(0, 0, 1, 64'(v), 0, v < 14);
    checkOutput("preRestartLevel", 64'(fifoLevel), DEPTH);
    checkOutput("preRestartOverflow", 64'(overflow), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("restartLevel", 64'(fifoLevel), 0);
    checkOutput("restartValid", 64'(rdValid), 0);
    checkOutput("restartCycles", 64'(cycleCount), 0);
    checkOutput("restartOuts", 64'(outCount), 0);
    checkOutput("restartDrops", 64'(dropCount), 0);
    checkOutput("restartOvf", 64'(overflow), 0);
    checkOutput("restartRunning", 64'(running), 1);

    // Reset mid-run with data buffered.
    applyStimulus(0, 0, 1, 55, 0, 1);
    idleCycles(1);
    applyReset();
    checkAllZero("midReset");

    checkOutput("scoreboardEmpty", 64'(expQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Synthesizable run controller and output capture unit that sits beside the cpu, replacing ad-hoc bench polling of halt/out_signal. It sequences a run (start → halt or timeout), counts cycles and cpu outputs, and buffers every out_data word in a parametrised FIFO so a host, bench or UART drains it at its own pace. Overflow and watchdog timeout are flagged sticky for post-run inspection.

Parameters:
DATA_W, 64, width of cpu out_data and FIFO entries
DEPTH, 16, FIFO entries; power of two, ≥2
CNT_W, 32, width of cycle and output counters
TIMEOUT, 100000, watchdog limit in RUN cycles; 0 disables watchdog

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; all state cleared on the clk edge where reset=1
start  in  1  one-cycle pulse; begins (or restarts) a run
cpu_halt  in  1  cpu halt
cpu_out_signal  in  1  cpu output strobe, one word per asserted cycle
cpu_out_data  in  DATA_W  cpu output word
rd_en  in  1  pop FIFO head
rd_data  out  DATA_W  FIFO head (show-ahead); 0 when empty
rd_valid  out  1  FIFO not empty
fifo_level  out  $clog2(DEPTH)+1  entries held
running  out  1  state==RUN
done  out  1  state==HALTED
timed_out  out  1  state==TIMEOUT
overflow  out  1  sticky: a word was dropped
cycle_count  out  CNT_W  cycles spent in RUN, saturating
out_count  out  CNT_W  cpu_out_signal pulses seen in RUN (incl. dropped), saturating
drop_count  out  CNT_W  words dropped, saturating

Behaviour:
- Reset: state IDLE; FIFO empty; all outputs 0 (rd_data 0, flags 0, counters 0).
- States: IDLE, RUN, HALTED, TIMEOUT. Status outputs are registered, decoded from state.
- IDLE→RUN on start. RUN→HALTED on cpu_halt. RUN→TIMEOUT when TIMEOUT≠0, cpu_halt=0 and cycle_count==TIMEOUT-1 (i.e. on the TIMEOUT-th RUN cycle). HALTED/TIMEOUT→RUN on start.
- start in any state (incl. RUN): next cycle state RUN, cycle_count/out_count/drop_count/overflow cleared, FIFO flushed. start has priority over cpu_halt, timeout, push and pop in the same cycle.
- cycle_count increments every RUN cycle, including the halt cycle; frozen outside RUN.
- Capture only in RUN: cpu_out_signal=1 → out_count++, push cpu_out_data. Outside RUN strobes ignored, nothing counted.
- Halt and out_signal in the same cycle: word captured, then HALTED.
- cpu_halt and timeout condition same cycle: HALTED wins, timed_out stays 0.
- FIFO push latency 1: word visible on rd_data/rd_valid the cycle after strobe.
- Pop: rd_en with rd_valid=1 removes head on the edge; rd_en when empty ignored, no underflow. Pop allowed in every state (drain after halt).
- Full, push without pop: word dropped, overflow←1 (sticky until start/reset), drop_count++. Full with simultaneous push and pop: both succeed, level stays DEPTH, no drop.
- Empty with simultaneous push and pop: pop ignored, push succeeds.
- Pointers wrap modulo DEPTH; level via extra pointer bit.
- Counters saturate at 2^CNT_W-1, no wrap.
- Reset mid-run: immediate return to IDLE, FIFO contents lost.

Decomposition:
- Package cpu_run_monitor_pkg: run_state_t enum {IDLE, RUN, HALTED, TIMEOUT}; default DATA_W/CNT_W constants shared with cpu; saturating-increment function.
- One sub-module: mon_fifo (sync show-ahead FIFO, params DATA_W/DEPTH, ports push/pop/flush/full/empty/level). FSM, counters, drop logic stay in top.

Test Plan:
- Reset, start, cpu outputs 5,7,9 on cycles 2,3,4, halt cycle 6 → fifo_level 3, done=1, cycle_count 6, out_count 3; pops return 5,7,9 then rd_valid=0.
- TIMEOUT=20, no halt → timed_out=1 after 20 RUN cycles, cycle_count 20; halt on cycle 21 ignored.
- DEPTH=4, 6 strobes values 1..6, no pops → FIFO holds 1..4, overflow=1, drop_count 2, out_count 6.
- Full FIFO, strobe+rd_en same cycle with value 99 → level stays 4, no drop, head advances, 99 at tail.
- Halt and strobe(42) same cycle → 42 captured, done=1; halt and timeout same cycle → done=1, timed_out=0.
- Start pulse while RUN with 3 words buffered → next cycle level 0, counters 0, overflow 0, running=1; reset mid-run → all outputs 0, IDLE.
